// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction-fetch stage. Issues sequential word addresses to instruction
//   memory over a req/ready handshake and buffers each returned word with its PC
//   in a DEPTH-entry FIFO for the decode stage. A redirect flushes the FIFO and
//   restarts fetch at a new PC. If the redirect arrives while a request is still
//   waiting, that request is completed first and its word is discarded.
//
//   Optional feature macro: FETCH_ALIGN_CHECK_EN
//     defined   : a misaligned redirect_pc sets a sticky fetch_except and halts
//                 fetch. A misaligned RESET_PC raises the flag out of reset.
//     undefined : redirect_pc[1:0] is forced to 2'b00 and fetch_except is 0.
//
//   Parameters
//     DEPTH     FIFO entries (power of 2, >= 2)
//     RESET_PC  first fetch address after reset
//
//   Ports
//     clk, reset               clock, async active-high reset
//     redirect, redirect_pc    flush queue and restart fetch at redirect_pc
//     imem_req, imem_addr      fetch request / word address
//     imem_ready, imem_data    memory accept and same-cycle returned word
//     inst_valid, inst,        head of queue (valid, instruction, PC)
//     inst_pc
//     inst_ready               consumer pop
//     fetch_except             sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_except
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic EXCEPT_RST = (RESET_PC[1:0] != 2'b00);
`else
  localparam logic EXCEPT_RST = 1'b0;
`endif

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_ABORT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     abort_pc_q, abort_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            except_q, except_d;

  logic [31:0]     data_mem_q [DEPTH];
  logic [31:0]     pc_mem_q   [DEPTH];

  logic            imem_req_s;
  logic            transfer_s;
  logic            push_s;
  logic            pop_s;
  logic            inst_valid_s;
  logic [31:0]     redir_pc_s;

  // Request generation and address mux; reset forces the request low.
  always_comb begin
    imem_req_s = 1'b0;
    case (state_q)
      // A raised exception stops all new fetches.
      ST_FETCH: imem_req_s = (count_q < DEPTH_C) && !except_q && !reset;
      // The abandoned request must still be completed.
      ST_ABORT: imem_req_s = !reset;
      default:  imem_req_s = 1'b0;
    endcase
  end

  assign imem_req     = imem_req_s;
  assign imem_addr    = (state_q == ST_ABORT) ? abort_pc_q : fetch_pc_q;
  assign transfer_s   = imem_req_s & imem_ready;
  assign inst_valid_s = (count_q != {CW{1'b0}});
  assign inst_valid   = inst_valid_s;
  assign inst         = data_mem_q[rd_ptr_q];
  assign inst_pc      = pc_mem_q[rd_ptr_q];
  assign fetch_except = except_q;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redir_pc_s = redirect_pc;
`else
  assign redir_pc_s = redirect_pc & 32'hFFFF_FFFC;
`endif

  // Next-state logic for the FSM, fetch PC, FIFO pointers and exception flag.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    abort_pc_d = abort_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    except_d   = except_q;
    push_s     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (redirect) begin
          // A waiting request cannot be withdrawn, so finish it in ABORT.
          if (imem_req_s && !imem_ready) begin
            abort_pc_d = fetch_pc_q;
            state_d    = ST_ABORT;
          end else begin
            state_d = ST_FETCH;
          end
        end else if (transfer_s) begin
          push_s     = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_ABORT: begin
        if (transfer_s) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_ABORT;
        end
      end
      default: state_d = ST_FETCH;
    endcase

    // The redirect takes priority over a pop in the same cycle.
    pop_s = inst_valid_s & inst_ready & ~redirect;

    if (redirect) begin
      count_d    = {CW{1'b0}};
      rd_ptr_d   = {PW{1'b0}};
      wr_ptr_d   = {PW{1'b0}};
      fetch_pc_d = redir_pc_s;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
    end

`ifdef FETCH_ALIGN_CHECK_EN
    if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      except_d = 1'b1;
    end else begin
      except_d = except_q;
    end
`else
    except_d = 1'b0;
`endif
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RESET_PC;
      abort_pc_q <= RESET_PC;
      count_q    <= {CW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      except_q   <= EXCEPT_RST;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      abort_pc_q <= abort_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      except_q   <= except_d;
    end
  end

  // FIFO storage. It is cleared on reset so inst/inst_pc read 0 before the first push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_q[i] <= 32'd0;
        pc_mem_q[i]   <= 32'd0;
      end
    end else if (push_s) begin
      data_mem_q[wr_ptr_q] <= imem_data;
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

endmodule
